// File: rtl/ib_ram_bank_wr_ctrl_if.sv
// ib_ram_bank_wr_ctrl_if: scheduler/ROM/RAM signal bundle for the IB bank write controller
interface ib_ram_bank_wr_ctrl_if #(
   parameter int BANK_NUM = 2,
   parameter int DEPTH    = 128,
   parameter int ITER_MAX = 15
);
   localparam int NB   = DEPTH / BANK_NUM;
   localparam int BA_W = NB > 1 ? $clog2(NB) : 1;
   localparam int RA_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int IT_W = $clog2(ITER_MAX + 1);
   logic                iter_rqst;
   logic                iter_termination;
   logic                load_mode;
   logic                rom_port_fetch;
   logic [RA_W-1:0]     rom_addr;
   logic                v3ib_rom_rst;
   logic                ram_mux_en;
   logic                ram_write_en;
   logic [BANK_NUM-1:0] ram_bank_we;
   logic [BA_W-1:0]     ram_waddr;
   logic                iter_update;
   logic [1:0]          busy;
   logic [2:0]          state;
   logic [IT_W-1:0]     iter_cnt;
   logic                load_done;
   modport master (
      output iter_rqst, iter_termination, load_mode,
      input  rom_port_fetch, rom_addr, v3ib_rom_rst, ram_mux_en, ram_write_en,
             ram_bank_we, ram_waddr, iter_update, busy, state, iter_cnt, load_done
   );
   modport slave (
      input  iter_rqst, iter_termination, load_mode,
      output rom_port_fetch, rom_addr, v3ib_rom_rst, ram_mux_en, ram_write_en,
             ram_bank_we, ram_waddr, iter_update, busy, state, iter_cnt, load_done
   );
endinterface

// File: rtl/ib_ram_bank_wr_ctrl.sv
// ib_ram_bank_wr_ctrl: sequences ROM fetches into interleaved RAM bank writes per iteration load
module ib_ram_bank_wr_ctrl #(
   parameter int BANK_NUM    = 2,
   parameter int DEPTH       = 128,
   parameter int ROM_LATENCY = 2,
   parameter int ITER_MAX    = 15
) (
   input logic                   write_clk,
   input logic                   rst,
   ib_ram_bank_wr_ctrl_if.slave  bus
);
   localparam int NB   = DEPTH / BANK_NUM;
   localparam int BA_W = NB > 1 ? $clog2(NB) : 1;
   localparam int RA_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int IT_W = $clog2(ITER_MAX + 1);
   localparam int FW   = RA_W + 1;
   typedef enum logic [2:0] {
      IDLE      = 3'b000,
      ROM_FETCH = 3'b001,
      RAM_LOAD  = 3'b010,
      FINISH    = 3'b100
   } state_t;
   state_t          state_q, state_d;
   logic [RA_W-1:0] cnt_q, cnt_d;
   logic [IT_W-1:0] iter_q, iter_d;
   logic            mode_q, mode_d, rqst_q, done_q, done_d;
   logic [FW-1:0]   n_len, fidx;
   logic            fetch, loading, active;
   // One counter serves both phases: fetch cycle in ROM_FETCH, write index in RAM_LOAD
   always_comb begin
      n_len   = mode_q ? FW'(DEPTH) : FW'(NB);
      loading = state_q == RAM_LOAD;
      active  = loading || state_q == ROM_FETCH;
      fidx    = loading ? FW'(cnt_q) + FW'(ROM_LATENCY) : FW'(cnt_q);
      fetch   = state_q == ROM_FETCH || (loading && fidx < n_len);
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      iter_d  = iter_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:
            if (bus.iter_rqst && !rqst_q && !bus.iter_termination) begin
               state_d = ROM_FETCH;
               cnt_d   = '0;
               mode_d  = bus.load_mode;
            end
         ROM_FETCH:
            if (bus.iter_termination) state_d = FINISH;
            else if (cnt_q == RA_W'(ROM_LATENCY - 1)) begin
               state_d = RAM_LOAD;
               cnt_d   = '0;
            end else cnt_d = cnt_q + RA_W'(1);
         RAM_LOAD:
            if (bus.iter_termination) state_d = FINISH;
            else if (FW'(cnt_q) == n_len - FW'(1)) begin
               state_d = FINISH;
               done_d  = 1'b1;
               iter_d  = iter_q == IT_W'(ITER_MAX) ? iter_q : iter_q + IT_W'(1);
            end else cnt_d = cnt_q + RA_W'(1);
         FINISH:
            if (!bus.iter_rqst) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge write_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         iter_q  <= '0;
         mode_q  <= 1'b0;
         rqst_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         iter_q  <= iter_d;
         mode_q  <= mode_d;
         rqst_q  <= bus.iter_rqst;
         done_q  <= done_d;
      end
   end
   assign bus.rom_port_fetch = fetch;
   assign bus.rom_addr       = fetch ? RA_W'(fidx) : '0;
   assign bus.v3ib_rom_rst   = state_q == IDLE || state_q == FINISH;
   assign bus.ram_mux_en     = loading;
   assign bus.ram_write_en   = loading;
   assign bus.ram_bank_we    = !loading ? '0 : mode_q ? BANK_NUM'(1) << (cnt_q % RA_W'(BANK_NUM)) : '1;
   assign bus.ram_waddr      = !loading ? '0 : mode_q ? BA_W'(cnt_q / RA_W'(BANK_NUM)) : BA_W'(cnt_q);
   assign bus.iter_update    = active;
   assign bus.busy           = {state_q == FINISH, active};
   assign bus.state          = state_q;
   assign bus.iter_cnt       = iter_q;
   assign bus.load_done      = done_q;
endmodule

// File: tb/tb_ib_ram_bank_wr_ctrl.sv
// tb_ib_ram_bank_wr_ctrl: directed + randomized loads against a per-cycle expectation model
module tb_ib_ram_bank_wr_ctrl;
   localparam int BANK_NUM    = 2;
   localparam int DEPTH       = 128;
   localparam int ROM_LATENCY = 2;
   localparam int ITER_MAX    = 15;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   exp_iter = 0;
   ib_ram_bank_wr_ctrl_if #(.BANK_NUM(BANK_NUM), .DEPTH(DEPTH), .ITER_MAX(ITER_MAX)) bus ();
   ib_ram_bank_wr_ctrl #(
      .BANK_NUM(BANK_NUM), .DEPTH(DEPTH), .ROM_LATENCY(ROM_LATENCY), .ITER_MAX(ITER_MAX)
   ) dut (
      .write_clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // {state, busy, iter_update, ram_mux_en, ram_write_en, v3ib_rom_rst, rom_port_fetch}
   function automatic logic [9:0] ctl();
      return {bus.state, bus.busy, bus.iter_update, bus.ram_mux_en, bus.ram_write_en,
              bus.v3ib_rom_rst, bus.rom_port_fetch};
   endfunction
   localparam logic [9:0] CTL_IDLE   = {3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [9:0] CTL_FETCH  = {3'b001, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [9:0] CTL_FINISH = {3'b100, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   task automatic run_load(input bit mode, input int abort_w, input int rst_w,
                           input int drop_w, input int hold);
      int  n, fetches, writes;
      bit  aborted, exp_f;
      n = mode ? DEPTH : DEPTH / BANK_NUM;
      fetches = 0;
      writes  = 0;
      aborted = 0;
      @(negedge clk);
      bus.load_mode = mode;
      bus.iter_rqst = 1'b1;
      for (int i = 0; i < ROM_LATENCY; i++) begin
         @(negedge clk);
         bus.load_mode = 1'($urandom);
         chk("fetch_ctl", 32'(ctl()), 32'(CTL_FETCH));
         chk("fetch_addr", 32'(bus.rom_addr), i);
         fetches += int'(bus.rom_port_fetch);
      end
      for (int w = 0; w < n; w++) begin
         @(negedge clk);
         exp_f = (w + ROM_LATENCY) < n;
         chk("load_ctl", 32'(ctl()), 32'({3'b010, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, exp_f}));
         if (exp_f) chk("load_rom_addr", 32'(bus.rom_addr), w + ROM_LATENCY);
         chk("bank_we", 32'(bus.ram_bank_we),
             mode ? (32'd1 << (w % BANK_NUM)) : (32'd1 << BANK_NUM) - 32'd1);
         chk("waddr", 32'(bus.ram_waddr), mode ? w / BANK_NUM : w);
         fetches += int'(bus.rom_port_fetch);
         writes  += int'(bus.ram_write_en);
         if (w == drop_w) bus.iter_rqst = 1'b0;
         if (w == rst_w) begin
            rst = 1'b1;
            #1;
            exp_iter = 0;
            chk("rst_state", 32'(bus.state), 0);
            chk("rst_wen", 32'(bus.ram_write_en), 0);
            chk("rst_romrst", 32'(bus.v3ib_rom_rst), 1);
            chk("rst_iter", 32'(bus.iter_cnt), 0);
            @(negedge clk);
            rst = 1'b0;
            bus.iter_rqst = 1'b0;
            @(negedge clk);
            chk("post_rst_ctl", 32'(ctl()), 32'(CTL_IDLE));
            return;
         end
         if (w == abort_w) begin
            bus.iter_termination = 1'b1;
            aborted = 1;
            break;
         end
      end
      @(negedge clk);
      bus.iter_termination = 1'b0;
      if (!aborted) exp_iter = exp_iter < ITER_MAX ? exp_iter + 1 : ITER_MAX;
      chk("writes", writes, aborted ? abort_w + 1 : n);
      if (!aborted) chk("fetch_total", fetches, n);
      chk("finish_ctl", 32'(ctl()), 32'(CTL_FINISH));
      chk("load_done", 32'(bus.load_done), aborted ? 0 : 1);
      chk("iter_cnt", 32'(bus.iter_cnt), exp_iter);
      for (int h = 0; h < hold && bus.iter_rqst; h++) begin
         @(negedge clk);
         chk("hold_ctl", 32'(ctl()), 32'(CTL_FINISH));
         chk("hold_done", 32'(bus.load_done), 0);
      end
      bus.iter_rqst = 1'b0;
      @(negedge clk);
      chk("idle_ctl", 32'(ctl()), 32'(CTL_IDLE));
      chk("idle_rom_addr", 32'(bus.rom_addr), 0);
      chk("idle_done", 32'(bus.load_done), 0);
   endtask
   initial begin
      bus.iter_rqst = 1'b0;
      bus.iter_termination = 1'b0;
      bus.load_mode = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_ctl", 32'(ctl()), 32'(CTL_IDLE));
      chk("reset_iter", 32'(bus.iter_cnt), 0);
      chk("reset_done", 32'(bus.load_done), 0);
      rst = 1'b0;
      run_load(1'b0, -1, -1, -1, 0);
      run_load(1'b1, -1, -1, -1, 0);
      run_load(1'b0, 10, -1, -1, 0);
      run_load(1'b1, 50, -1, -1, 2);
      // rising edge masked by termination, then a held level must not start a load
      @(negedge clk);
      bus.iter_rqst = 1'b1;
      bus.iter_termination = 1'b1;
      @(negedge clk);
      chk("masked_start", 32'(bus.state), 0);
      bus.iter_termination = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("held_no_start", 32'(bus.state), 0);
      end
      bus.iter_rqst = 1'b0;
      run_load(1'b0, -1, -1, -1, 200 - (ROM_LATENCY + DEPTH / BANK_NUM + 1));
      run_load(1'b0, -1, -1, 20, 0);
      for (int k = 0; k < 17; k++) begin
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("gap_idle", 32'(bus.state), 0);
         end
         run_load(1'($urandom), -1, -1,
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 60) : -1,
                  $urandom_range(0, 4));
      end
      chk("saturated", 32'(bus.iter_cnt), ITER_MAX);
      for (int k = 0; k < 4; k++)
         run_load(1'($urandom), $urandom_range(0, 60), -1, -1, $urandom_range(0, 2));
      run_load(1'b0, -1, 30, -1, 0);
      run_load(1'b1, -1, -1, -1, 1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ib_ram_bank_wr_ctrl.md
Name: ib_ram_bank_wr_ctrl

Overview:
Parametrised write-sequencing controller for IB ROM→RAM iteration updates in the decoding-process-control path. It generalises the dnu3-style write FSM to any bank count, depth and ROM read latency. It supports parallel (all banks per cycle) and serial (round-robin bank) load modes, and keeps an iteration counter. It drives ROM fetch/address, RAM bank write enables and address, the RAM mux select, and busy/status back to the iteration scheduler.

Parameters:
BANK_NUM, 2, number of interleaved RAM banks; power of two, ≥1
DEPTH, 128, total IB entries across all banks; multiple of BANK_NUM
ROM_LATENCY, 2, cycles from rom_addr presented to ROM data valid; ≥1, < DEPTH/BANK_NUM
ITER_MAX, 15, saturation value of iter_cnt
Derived widths: BA_W = $clog2(DEPTH/BANK_NUM) (min 1); RA_W = $clog2(DEPTH); IT_W = $clog2(ITER_MAX+1)

Ports:
write_clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
iter_rqst  in  1  level request; a rising edge starts one load
iter_termination  in  1  abort current load / block start
load_mode  in  1  0 = parallel, 1 = serial; sampled at start
rom_port_fetch  out  1  ROM read enable
rom_addr  out  RA_W  ROM read index
v3ib_rom_rst  out  1  ROM output reset
ram_mux_en  out  1  RAM write-data mux select toward ROM
ram_write_en  out  1  any bank being written
ram_bank_we  out  BANK_NUM  per-bank write enable
ram_waddr  out  BA_W  bank-local write address
iter_update  out  1  update in progress
busy  out  2  00 idle, 01 updating, 10 finish
state  out  3  current FSM state
iter_cnt  out  IT_W  completed loads, saturating
load_done  out  1  one-cycle pulse on normal completion

Behaviour:
- rst asserted (async): state=IDLE. All counters, iter_cnt, mode register and the iter_rqst edge register clear. load_done=0. Outputs take their IDLE decode. rst mid-load abandons the load with no further writes.
- N = DEPTH/BANK_NUM in parallel mode; N = DEPTH in serial mode.
- States: IDLE 000, ROM_FETCH 001, RAM_LOAD 010, FINISH 100.
- IDLE: rising edge of iter_rqst (registered previous value is 0, current is 1) with iter_termination=0 → ROM_FETCH on the next edge; load_mode is latched on that edge. A rising edge coinciding with iter_termination=1 is ignored.
- ROM_FETCH: lasts exactly ROM_LATENCY cycles. rom_addr presents indices 0..ROM_LATENCY-1. Then → RAM_LOAD.
- RAM_LOAD: lasts exactly N cycles, with write index w = 0..N-1.
  - rom_port_fetch stays 1 while the fetch index < N, i.e. for the first N-ROM_LATENCY cycles; then 0.
  - Parallel: ram_bank_we = all ones, ram_waddr = w.
  - Serial: ram_bank_we = one-hot(w mod BANK_NUM), ram_waddr = w / BANK_NUM.
  - After cycle w=N-1 → FINISH.
- Output decode: rom_port_fetch=1 for all of ROM_FETCH and as above in RAM_LOAD. iter_update=1 in ROM_FETCH and RAM_LOAD. ram_mux_en=ram_write_en=1 in RAM_LOAD. v3ib_rom_rst=1 in IDLE and FINISH. busy = 00 IDLE, 01 ROM_FETCH/RAM_LOAD, 10 FINISH.
- rom_addr: parallel mode = fetch index zero-extended; serial mode = linear fetch index. rom_addr = 0 outside ROM_FETCH/RAM_LOAD.
- iter_termination=1 in ROM_FETCH or RAM_LOAD → FINISH on the next edge. The write in progress that cycle completes; no further writes. No load_done, no iter_cnt increment.
- Normal completion: load_done=1 in the first FINISH cycle only (registered). iter_cnt increments on the same edge and saturates at ITER_MAX.
- FINISH: stay while iter_rqst=1; → IDLE when iter_rqst=0. A new start requires a fresh rising edge seen in IDLE; holding iter_rqst high never retriggers.
- iter_rqst falling during ROM_FETCH/RAM_LOAD has no effect; the load completes.

Test Plan:
- Parallel, defaults: one rising edge → 2 ROM_FETCH cycles, then 64 RAM_LOAD cycles with ram_bank_we=2'b11 and ram_waddr 0..63; rom_port_fetch high 64 cycles total; load_done pulses once; iter_cnt=1.
- Serial, defaults: 128 RAM_LOAD cycles; ram_bank_we alternates 01/10; ram_waddr increments every 2 cycles to 63; rom_addr reaches 127.
- Abort: iter_termination=1 at RAM_LOAD w=10 → 11 writes total, FINISH next cycle, no load_done, iter_cnt unchanged.
- Hold iter_rqst=1 for 200 cycles: exactly one load; FINISH held with busy=10 until iter_rqst=0, then IDLE with busy=00.
- Saturation: 17 back-to-back loads → iter_cnt stays 15 after the 15th load.
- Async rst asserted at RAM_LOAD w=30 → immediately state=000, ram_write_en=0, v3ib_rom_rst=1, iter_cnt=0.
